// File: rtl/lsu_axi_controller_pkg.sv
// Shared types and constants for the load/store unit.
// - mem_size_e  : access width encoding driven by the decoder
// - lsu_state_e : sequencer states
// - RESP_*      : AXI response codes the LSU cares about
// - norm_size() : folds the unused size encoding onto WORD
package lsu_axi_controller_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } lsu_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Encoding 3 is not a legal size; it behaves exactly like a word access.
  function automatic mem_size_e norm_size(input logic [1:0] raw);
    case (raw)
      2'd0:    return SIZE_BYTE;
      2'd1:    return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering for the LSU (pure combinational).
// Store side (request-time inputs):
//   req_size, req_off, store_data -> misaligned, wstrb, wdata
// Load side (latched request attributes + returned bus data):
//   ld_size, ld_off, ld_unsigned, rdata -> load_ext
module lsu_data_align
  import lsu_axi_controller_pkg::*;
(
  input  mem_size_e   req_size,
  input  logic [1:0]  req_off,
  input  logic [31:0] store_data,
  output logic        misaligned,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  mem_size_e   ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] load_ext
);

  logic [31:0] shifted;

  // Narrow stores replicate the operand across all lanes so the strobe alone
  // selects which copy lands in memory.
  always_comb begin
    misaligned = 1'b0;
    wstrb      = 4'b1111;
    wdata      = store_data;
    case (req_size)
      SIZE_BYTE: begin
        wstrb = 4'b0001 << req_off;
        wdata = {4{store_data[7:0]}};
      end
      SIZE_HALF: begin
        wstrb      = 4'b0011 << req_off;
        wdata      = {2{store_data[15:0]}};
        misaligned = req_off[0];
      end
      default: begin
        misaligned = |req_off;
      end
    endcase
  end

  // Bring the addressed bytes down to bit 0, then extend to the register width.
  always_comb begin
    shifted  = rdata >> {ld_off, 3'b000};
    load_ext = shifted;
    case (ld_size)
      SIZE_BYTE: load_ext = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_ext = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
      default:   load_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_axi_controller.sv
// Load/store sequencer: turns one core memory instruction into a single
// AXI4-Lite read or write, stalling the core until the response returns.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   mem_req/mem_we/mem_size/... : request from execute (held while stall=1)
//   load_data, stall, mem_err   : results back to the core
//   aw*/w*/b*                   : AXI4-Lite write channels (master side)
//   ar*/r*                      : AXI4-Lite read channels (master side)
module lsu_axi_controller
  import lsu_axi_controller_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              mem_err,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  mem_size_e         size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;

  mem_size_e   req_size;
  logic        misaligned;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic [31:0] load_ext;

  assign req_size = norm_size(mem_size);

  lsu_data_align u_align (
    .req_size    (req_size),
    .req_off     (addr[1:0]),
    .store_data  (store_data),
    .misaligned  (misaligned),
    .wstrb       (req_wstrb),
    .wdata       (req_wdata),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (unsigned_q),
    .rdata       (rdata),
    .load_ext    (load_ext)
  );

  // Request attributes are captured when IDLE accepts, so later changes on the
  // core side cannot disturb a transaction already in flight.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    off_d       = off_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          addr_d      = {addr[ADDR_W-1:2], 2'b00};
          off_d       = addr[1:0];
          size_d      = req_size;
          unsigned_d  = mem_unsigned;
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          err_d       = 1'b0;
          load_data_d = '0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (mem_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        // Address and data channels complete independently, in any order.
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          bready_d = 1'b0;
          err_d    = (bresp != RESP_OKAY);
          state_d  = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (rvalid) begin
          rready_d    = 1'b0;
          err_d       = (rresp != RESP_OKAY);
          load_data_d = (rresp != RESP_OKAY) ? '0 : load_ext;
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      off_q       <= '0;
      size_q      <= SIZE_BYTE;
      unsigned_q  <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  // Stall is combinational so the core freezes in the very cycle a request appears.
  assign stall     = mem_req && (state_q != ST_DONE);
  assign mem_err   = (state_q == ST_DONE) && err_q;
  assign load_data = load_data_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule
